// File: rtl/inference_controller.sv
// Walks the image buffer, streams nonzero pixels as events to the SNN core, then runs the core and holds its result.
// Optional WAIT_DONE watchdog: define INFERENCE_CONTROLLER_TIMEOUT_EN.
module inference_controller #(
    parameter int unsigned IMAGE_SIZE      = 256,
    parameter int unsigned IMAGE_SIZE_BITS = 8,
    parameter int unsigned PIXEL_BITS      = 8,
    parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic                       NEW_IMAGE,
    output logic [IMAGE_SIZE_BITS-1:0] PIXEL_ADDR,
    input  logic [PIXEL_BITS-1:0]      PIXEL_DATA,
    output logic                       EVT_VALID,
    input  logic                       EVT_READY,
    output logic [IMAGE_SIZE_BITS-1:0] EVT_ADDR,
    output logic [PIXEL_BITS-1:0]      EVT_VAL,
    output logic                       SNN_START,
    input  logic                       SNN_DONE,
    input  logic [7:0]                 SNN_DIGIT,
    output logic [7:0]                 INFERED_DIGIT,
    output logic                       COPROCESSOR_RDY,
    input  logic                       RESULT_ACK,
    output logic                       BUSY,
    output logic                       OVERRUN,
    output logic [IMAGE_SIZE_BITS:0]   EVT_COUNT
);

    typedef enum logic [1:0] {IDLE, SCAN, WAIT_DONE, DONE} state_t;

    localparam logic [IMAGE_SIZE_BITS-1:0] LAST_ADDR = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);

    state_t state;
    logic   pixel_hit;
    logic   pixel_done;
    logic   timeout_hit;

    // The buffer read is combinational, so the event is presented in the same cycle the pixel is addressed.
    assign pixel_hit  = (state == SCAN) && (PIXEL_DATA != '0);
    assign pixel_done = (state == SCAN) && (!pixel_hit || EVT_READY);
    assign EVT_VALID  = pixel_hit;
    assign EVT_ADDR   = pixel_hit ? PIXEL_ADDR : '0;
    assign EVT_VAL    = pixel_hit ? PIXEL_DATA : '0;
    assign BUSY       = (state == SCAN) || (state == WAIT_DONE);

`ifdef INFERENCE_CONTROLLER_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] wait_cnt;

    assign timeout_hit = (state == WAIT_DONE) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wait_cnt <= '0;
        end else if (state != WAIT_DONE) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state           <= IDLE;
            PIXEL_ADDR      <= '0;
            EVT_COUNT       <= '0;
            SNN_START       <= 1'b0;
            INFERED_DIGIT   <= '0;
            COPROCESSOR_RDY <= 1'b0;
            OVERRUN         <= 1'b0;
        end else begin
            SNN_START <= 1'b0;
            case (state)
                IDLE: begin
                    if (NEW_IMAGE) begin
                        state           <= SCAN;
                        PIXEL_ADDR      <= '0;
                        EVT_COUNT       <= '0;
                        COPROCESSOR_RDY <= 1'b0;
                        OVERRUN         <= 1'b0;
                    end
                end
                SCAN: begin
                    if (NEW_IMAGE) begin
                        OVERRUN <= 1'b1;
                    end
                    if (pixel_hit && EVT_READY) begin
                        EVT_COUNT <= EVT_COUNT + 1'b1;
                    end
                    // Address parks on the last pixel rather than wrapping.
                    if (pixel_done) begin
                        if (PIXEL_ADDR == LAST_ADDR) begin
                            state     <= WAIT_DONE;
                            SNN_START <= 1'b1;
                        end else begin
                            PIXEL_ADDR <= PIXEL_ADDR + 1'b1;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (NEW_IMAGE) begin
                        OVERRUN <= 1'b1;
                    end
                    if (SNN_DONE) begin
                        INFERED_DIGIT   <= SNN_DIGIT;
                        COPROCESSOR_RDY <= 1'b1;
                        state           <= DONE;
                    end else if (timeout_hit) begin
                        INFERED_DIGIT   <= 8'hFF;
                        COPROCESSOR_RDY <= 1'b1;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    // A new image takes priority over acknowledging the old result.
                    if (NEW_IMAGE) begin
                        state           <= SCAN;
                        PIXEL_ADDR      <= '0;
                        EVT_COUNT       <= '0;
                        COPROCESSOR_RDY <= 1'b0;
                        OVERRUN         <= 1'b0;
                    end else if (RESULT_ACK) begin
                        COPROCESSOR_RDY <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inference_controller.sv
// Scoreboard bench for inference_controller: expected events/digits queued at stimulus, checked by a monitor.
module tb_inference_controller;

    localparam int IMG = 256;

    logic       ACLK = 1'b0;
    logic       ARESETN = 1'b1;
    logic       NEW_IMAGE = 1'b0;
    logic       EVT_READY = 1'b0;
    logic       SNN_DONE = 1'b0;
    logic       RESULT_ACK = 1'b0;
    logic [7:0] SNN_DIGIT = 8'd0;
    logic [7:0] PIXEL_ADDR, PIXEL_DATA, EVT_ADDR, EVT_VAL, INFERED_DIGIT;
    logic       EVT_VALID, SNN_START, COPROCESSOR_RDY, BUSY, OVERRUN;
    logic [8:0] EVT_COUNT;

    logic [7:0] img [IMG];
    assign PIXEL_DATA = img[PIXEL_ADDR];

    always #5 ACLK = ~ACLK;

    inference_controller #(
        .IMAGE_SIZE(256),
        .IMAGE_SIZE_BITS(8),
        .PIXEL_BITS(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .NEW_IMAGE(NEW_IMAGE),
        .PIXEL_ADDR(PIXEL_ADDR), .PIXEL_DATA(PIXEL_DATA),
        .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_ADDR(EVT_ADDR), .EVT_VAL(EVT_VAL),
        .SNN_START(SNN_START), .SNN_DONE(SNN_DONE), .SNN_DIGIT(SNN_DIGIT),
        .INFERED_DIGIT(INFERED_DIGIT), .COPROCESSOR_RDY(COPROCESSOR_RDY), .RESULT_ACK(RESULT_ACK),
        .BUSY(BUSY), .OVERRUN(OVERRUN), .EVT_COUNT(EVT_COUNT)
    );

    typedef struct {int addr; int val;} evt_t;
    evt_t       exp_evt[$];
    logic [7:0] exp_digit[$];
    int compared = 0, mismatched = 0;
    int ready_mode = 0;
    int exp_starts = 0, seen_starts = 0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // EVT_READY: 0 = always ready, 1 = low for 5 cycles per event, 2 = random
    initial begin
        int stall = 0;
        forever begin
            @(posedge ACLK);
            #2;
            if (!EVT_VALID) begin
                stall = 0;
                EVT_READY = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 0);
            end else if (ready_mode == 0) begin
                EVT_READY = 1'b1;
            end else if (ready_mode == 1) begin
                EVT_READY = (stall >= 5);
                stall = EVT_READY ? 0 : stall + 1;
            end else begin
                EVT_READY = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: handshakes, stall stability, start pulses, result delivery
    initial begin
        logic       pv = 1'b0, pr = 1'b0, ps = 1'b0, prdy = 1'b0;
        logic [7:0] pa = '0, pval = '0;
        evt_t       e;
        logic [7:0] d;
        forever begin
            @(negedge ACLK);
            if (EVT_VALID && pv && !pr) begin
                check("evt_addr_stable", int'(EVT_ADDR), int'(pa));
                check("evt_val_stable", int'(EVT_VAL), int'(pval));
            end
            if (EVT_VALID && EVT_READY) begin
                if (exp_evt.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL evt_unexpected: got addr %0d val %0d expected no event", EVT_ADDR, EVT_VAL);
                end else begin
                    e = exp_evt.pop_front();
                    check("evt_addr", int'(EVT_ADDR), e.addr);
                    check("evt_val", int'(EVT_VAL), e.val);
                end
            end
            if (SNN_START) begin
                seen_starts++;
                check("snn_start_single_cycle", int'(ps), 0);
            end
            if (COPROCESSOR_RDY && !prdy) begin
                if (exp_digit.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL rdy_unexpected: got digit %0d expected no result", INFERED_DIGIT);
                end else begin
                    d = exp_digit.pop_front();
                    check("infered_digit", int'(INFERED_DIGIT), int'(d));
                end
            end
            pv = EVT_VALID; pr = EVT_READY; pa = EVT_ADDR; pval = EVT_VAL;
            ps = SNN_START; prdy = COPROCESSOR_RDY;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    task automatic clear_img();
        for (int i = 0; i < IMG; i++) img[i] = 8'd0;
    endtask

    task automatic rand_img();
        for (int i = 0; i < IMG; i++)
            img[i] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
    endtask

    task automatic start_image(input bit completes, input bit with_ack, output int nev);
        nev = 0;
        for (int i = 0; i < IMG; i++) begin
            if (img[i] != 0) begin
                exp_evt.push_back('{i, int'(img[i])});
                nev++;
            end
        end
        if (completes) exp_starts++;
        NEW_IMAGE = 1'b1;
        RESULT_ACK = with_ack;
        tick();
        NEW_IMAGE = 1'b0;
        RESULT_ACK = 1'b0;
        check("start_busy", int'(BUSY), 1);
        check("start_addr", int'(PIXEL_ADDR), 0);
        check("start_count", int'(EVT_COUNT), 0);
        check("start_overrun", int'(OVERRUN), 0);
        check("start_rdy", int'(COPROCESSOR_RDY), 0);
    endtask

    task automatic wait_start(input int nev, input int ovr_at);
        int  n = 0;
        bit  done = 0;
        while (!done && n < 3000) begin
            NEW_IMAGE = (n == ovr_at);
            tick();
            NEW_IMAGE = 1'b0;
            n++;
            if (ovr_at >= 0 && n == ovr_at + 1) check("overrun_set", int'(OVERRUN), 1);
            if (SNN_START) done = 1;
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL snn_start_timeout: got no SNN_START in %0d cycles expected one", n);
        end
        if (ready_mode == 0) check("scan_cycles", n, IMG);
        if (ready_mode == 1) check("scan_cycles_stalled", n, IMG + 5 * nev);
        check("evt_count", int'(EVT_COUNT), nev);
        check("addr_parked", int'(PIXEL_ADDR), IMG - 1);
        check("busy_wait", int'(BUSY), 1);
        check("overrun_hold", int'(OVERRUN), (ovr_at >= 0) ? 1 : 0);
    endtask

    task automatic finish_image(input logic [7:0] d, input int idle_wait);
        for (int k = 0; k < idle_wait; k++) begin
            RESULT_ACK = 1'b1;
            tick();
            RESULT_ACK = 1'b0;
            check("wait_ack_ignored", int'(COPROCESSOR_RDY), 0);
            check("wait_busy", int'(BUSY), 1);
        end
        SNN_DIGIT = d;
        SNN_DONE = 1'b1;
        exp_digit.push_back(d);
        tick();
        SNN_DONE = 1'b0;
        SNN_DIGIT = 8'($urandom_range(0, 255));
        check("done_rdy", int'(COPROCESSOR_RDY), 1);
        check("done_busy", int'(BUSY), 0);
    endtask

    task automatic ack(input logic [7:0] d);
        RESULT_ACK = 1'b1;
        tick();
        RESULT_ACK = 1'b0;
        check("ack_rdy_clear", int'(COPROCESSOR_RDY), 0);
        check("ack_idle", int'(BUSY), 0);
        check("ack_digit_hold", int'(INFERED_DIGIT), int'(d));
    endtask

    initial begin
        int         nev;
        logic [7:0] d;
        clear_img();
        #1 ARESETN = 1'b0;
        #2;
        check("rst_busy", int'(BUSY), 0);
        check("rst_valid", int'(EVT_VALID), 0);
        check("rst_start", int'(SNN_START), 0);
        check("rst_rdy", int'(COPROCESSOR_RDY), 0);
        check("rst_overrun", int'(OVERRUN), 0);
        check("rst_count", int'(EVT_COUNT), 0);
        check("rst_addr", int'(PIXEL_ADDR), 0);
        check("rst_digit", int'(INFERED_DIGIT), 0);
        #20 ARESETN = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("idle_after_reset", int'(BUSY), 0);

        // Core/result strobes outside their states are ignored
        SNN_DONE = 1'b1; SNN_DIGIT = 8'd9; RESULT_ACK = 1'b1;
        tick();
        SNN_DONE = 1'b0; RESULT_ACK = 1'b0;
        check("idle_done_ignored", int'(COPROCESSOR_RDY), 0);
        check("idle_digit_unchanged", int'(INFERED_DIGIT), 0);

        // Two-event image, always ready
        clear_img(); img[3] = 8'd81; img[200] = 8'd45;
        ready_mode = 0;
        start_image(1, 0, nev);
        check("two_event_image", nev, 2);
        wait_start(nev, -1);
        finish_image(8'd7, 2);
        ack(8'd7);

        // Same image with 5-cycle stalls per event
        ready_mode = 1;
        start_image(1, 0, nev);
        wait_start(nev, -1);
        finish_image(8'd3, 0);
        ack(8'd3);

        // All-zero image
        clear_img(); ready_mode = 0;
        start_image(1, 0, nev);
        wait_start(nev, -1);
`ifdef INFERENCE_CONTROLLER_TIMEOUT_EN
        begin
            int n = 0;
            exp_digit.push_back(8'hFF);
            while (!COPROCESSOR_RDY && n < 100) begin
                tick();
                n++;
            end
            check("timeout_cycles", n, 16);
            check("timeout_digit", int'(INFERED_DIGIT), 255);
            ack(8'hFF);
        end
`else
        for (int i = 0; i < 40; i++) tick();
        check("wait_indefinite_rdy", int'(COPROCESSOR_RDY), 0);
        check("wait_indefinite_busy", int'(BUSY), 1);
        finish_image(8'd5, 0);
        ack(8'd5);
`endif

        // Overrun during scan, then NEW_IMAGE together with RESULT_ACK in DONE
        rand_img(); img[0] = 8'd17; img[255] = 8'd99;
        ready_mode = 2;
        start_image(1, 0, nev);
        wait_start(nev, 50);
        d = 8'($urandom_range(0, 255));
        finish_image(d, 1);
        check("overrun_in_done", int'(OVERRUN), 1);
        rand_img();
        start_image(1, 1, nev);
        wait_start(nev, -1);
        d = 8'($urandom_range(0, 255));
        finish_image(d, 0);
        ack(d);

        // Asynchronous reset while an event is stalled at pixel 100
        clear_img(); img[100] = 8'd200; img[150] = 8'd1;
        ready_mode = 1;
        start_image(0, 0, nev);
        begin
            int n = 0;
            while (!(EVT_VALID && PIXEL_ADDR == 8'd100) && n < 1000) begin
                tick();
                n++;
            end
            check("reached_pixel_100", int'(PIXEL_ADDR), 100);
        end
        #2 ARESETN = 1'b0;
        exp_evt.delete();
        #1;
        check("arst_valid", int'(EVT_VALID), 0);
        check("arst_evt_addr", int'(EVT_ADDR), 0);
        check("arst_evt_val", int'(EVT_VAL), 0);
        check("arst_addr", int'(PIXEL_ADDR), 0);
        check("arst_busy", int'(BUSY), 0);
        check("arst_count", int'(EVT_COUNT), 0);
        check("arst_digit", int'(INFERED_DIGIT), 0);
        #20 ARESETN = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("post_arst_idle", int'(BUSY), 0);
        check("post_arst_addr", int'(PIXEL_ADDR), 0);

        // Randomised images
        for (int r = 0; r < 5; r++) begin
            rand_img();
            ready_mode = $urandom_range(0, 2);
            start_image(1, 0, nev);
            wait_start(nev, -1);
            d = 8'($urandom_range(0, 255));
            finish_image(d, $urandom_range(0, 4));
            ack(d);
        end

        for (int i = 0; i < 3; i++) tick();
        check("events_drained", exp_evt.size(), 0);
        check("digits_drained", exp_digit.size(), 0);
        check("snn_start_pulses", seen_starts, exp_starts);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
